toycpu_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the toycpu processor core.

---
 rtl/toycpu_fetch.sv | 120 ++++++++++++
 tb/tb_toycpu_fetch.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toycpu_fetch.sv
// Instruction fetch stage for the toycpu core: issues word-addressed reads,
// buffers returned words in a small prefetch FIFO and hands {instruction, pc}
// to the core over a valid/ready handshake. Redirect flushes and restarts.
module toycpu_fetch #(
  parameter int unsigned         ADDR_W   = 16,
  parameter int unsigned         DATA_W   = 16,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_W-1:0]        instruction,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthExt = (CntW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   discard_q, discard_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic credit, issue, push, pop;

  // Credit counts in-flight reads as already occupying FIFO slots, so a
  // returning word always has room.
  always_comb begin
    credit      = ({1'b0, outstanding_q} + {1'b0, count_q}) < DepthExt;
    mem_req     = !rst && !redirect && credit;
    mem_addr    = fetch_pc_q;
    issue       = mem_req && mem_gnt;
    instr_valid = count_q != '0;
    pop         = instr_valid && instr_ready;
    push        = mem_rvalid && (discard_q == '0);
    instruction = instr_valid ? fifo_data_q[rptr_q] : '0;
    instr_pc    = instr_valid ? fifo_pc_q[rptr_q] : '0;
    fifo_count  = count_q;
  end

  // Next-state: redirect wins over issue, push and pop in the same cycle.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    if (redirect) begin
      fetch_pc_d    = redirect_pc;
      resp_pc_d     = redirect_pc;
      // Every read still in flight after this cycle is stale.
      outstanding_d = outstanding_q - CntW'(mem_rvalid);
      discard_d     = outstanding_q - CntW'(mem_rvalid);
      count_d       = '0;
      wptr_d        = '0;
      rptr_d        = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      outstanding_d = outstanding_q + CntW'(issue) - CntW'(mem_rvalid);
      if (mem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CntW'(1);
        end else begin
          resp_pc_d = resp_pc_q + ADDR_W'(1);
          wptr_d    = wptr_q + PtrW'(1);
        end
      end
      if (pop) rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  // FIFO storage; contents are only visible through the valid-gated outputs.
  always_ff @(posedge clk) begin
    if (!redirect && push) begin
      fifo_pc_q[wptr_q]   <= resp_pc_q;
      fifo_data_q[wptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_toycpu_fetch.sv
// Directed bench for toycpu_fetch with a behavioural in-order memory model.
module tb_toycpu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instruction;
  logic [15:0] instr_pc;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;
  int lat = 1;
  int cyc = 0;
  int grants = 0;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;
  req_t pend[$];

  toycpu_fetch #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (4),
    .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .instr_pc   (instr_pc),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Memory: samples grants at posedge, drives rvalid/rdata at negedge for the next edge.
  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
    end else begin
      if (mem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (mem_req && mem_gnt) begin
        pend.push_back('{addr: mem_addr, due: cyc + lat});
        grants++;
      end
    end
    @(negedge clk);
    if (rst) pend.delete();
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rom(pend[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end

  // Hold reset two cycles, then release at a negedge.
  task automatic start(input int latency);
    lat = latency;
    rst = 1'b1;
    redirect = 1'b0;
    mem_gnt = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    grants = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({instr_valid, instruction, instr_pc, fifo_count, mem_req, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b i=%h pc=%h cnt=%0d req=%b addr=%h want all 0",
               instr_valid, instruction, instr_pc, fifo_count, mem_req, mem_addr);
    end
  endtask

  task automatic test_stream();
    start(1);
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_latency_early: got valid=%b want 0", instr_valid);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({instr_valid, instr_pc, instruction} !== {1'b1, 16'(i), rom(16'(i))}) begin
        miscompares++;
        $display("FAIL stream_seq: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 instr_valid, instr_pc, instruction, 16'(i), rom(16'(i)));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    int got;
    start(1);
    instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (grants !== 4) begin
      miscompares++;
      $display("FAIL bp_grants: got %0d want 4", grants);
    end
    vectors++;
    if ({fifo_count, mem_req} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_full: got cnt=%0d req=%b want cnt=4 req=0", fifo_count, mem_req);
    end
    instr_ready = 1'b1;
    exp = 16'h0000;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      if (instr_valid) begin
        vectors++;
        if ({instr_pc, instruction} !== {exp, rom(exp)}) begin
          miscompares++;
          $display("FAIL bp_drain: got pc=%h i=%h want pc=%h i=%h",
                   instr_pc, instruction, exp, rom(exp));
        end
        exp++;
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got !== 10) begin
      miscompares++;
      $display("FAIL bp_timeout: got %0d instrs want 10", got);
    end
  endtask

  task automatic test_redirect_flush();
    logic [15:0] exp;
    int got;
    start(3);
    repeat (3) @(negedge clk);
    vectors++;
    if ({grants, instr_valid} !== {32'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL rd_inflight: got grants=%0d v=%b want 3 0", grants, instr_valid);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_req_mask: got req=%b want 0", mem_req);
    end
    @(negedge clk);
    redirect = 1'b0;
    exp = 16'h0040;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (instr_valid) begin
        vectors++;
        if ({instr_pc, instruction} !== {exp, rom(exp)}) begin
          miscompares++;
          $display("FAIL rd_target: got pc=%h i=%h want pc=%h i=%h",
                   instr_pc, instruction, exp, rom(exp));
        end
        exp++;
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL rd_timeout: got %0d instrs want 4", got);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    int got;
    start(2);
    exp = 16'h0000;
    got = 0;
    for (int c = 0; c < 3000 && got < 200; c++) begin
      mem_gnt = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      vectors++;
      if (fifo_count > 3'd4) begin
        miscompares++;
        $display("FAIL rnd_count: got %0d want <=4", fifo_count);
      end
      if (instr_valid && instr_ready) begin
        vectors++;
        if ({instr_pc, instruction} !== {exp, rom(exp)}) begin
          miscompares++;
          $display("FAIL rnd_seq: got pc=%h i=%h want pc=%h i=%h",
                   instr_pc, instruction, exp, rom(exp));
        end
        exp++;
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got !== 200) begin
      miscompares++;
      $display("FAIL rnd_timeout: got %0d instrs want 200", got);
    end
    mem_gnt = 1'b1;
    instr_ready = 1'b1;
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    int got;
    start(1);
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    exp = 16'hFFFE;
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (instr_valid) begin
        vectors++;
        if ({instr_pc, instruction} !== {exp, rom(exp)}) begin
          miscompares++;
          $display("FAIL wrap_seq: got pc=%h i=%h want pc=%h i=%h",
                   instr_pc, instruction, exp, rom(exp));
        end
        exp++;
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got !== 4) begin
      miscompares++;
      $display("FAIL wrap_timeout: got %0d instrs want 4", got);
    end
  endtask

  task automatic test_reset_midstream();
    start(1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({instr_valid, instruction, instr_pc, fifo_count, mem_req, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL midrst_state: got v=%b i=%h pc=%h cnt=%0d req=%b addr=%h want all 0",
               instr_valid, instruction, instr_pc, fifo_count, mem_req, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({instr_valid, instr_pc, instruction} !== {1'b1, 16'h0000, rom(16'h0000)}) begin
      miscompares++;
      $display("FAIL midrst_restart: got v=%b pc=%h i=%h want v=1 pc=0000 i=%h",
               instr_valid, instr_pc, instruction, rom(16'h0000));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_random();
    test_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
